// File: rtl/detransformer_pipe.sv
// Sequential inverse transform for one compressed line: rebuilds LANES words per cycle from a
// base word plus per-word differences and reports the predictor applied to every word.
module detransformer_pipe #(
  parameter int DATA_W = 256,
  parameter int WORD_W = 32,
  parameter int LANES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] pred_o,
  output logic              busy_o
);

  localparam int Words = DATA_W / WORD_W;
  localparam int Steps = Words / LANES;
  localparam int StepW = (Steps > 1) ? $clog2(Steps) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   in_q;
  logic [1:0]          mode_q;
  logic [StepW-1:0]    step_q;
  logic [WORD_W-1:0]   prev_q;
  logic [DATA_W-1:0]   work_data_q, work_data_d;
  logic [DATA_W-1:0]   work_pred_q, work_pred_d;
  logic [WORD_W-1:0]   prev_d;
  logic [WORD_W-1:0]   base, word, p, o;
  logic                last_step, accept;
  int                  k;

  assign ready_o   = !rst && ((state_q == StIdle) || (state_q == StHold && ready_i));
  assign accept    = valid_i && ready_o;
  assign last_step = (step_q == StepW'(Steps - 1));
  assign base      = in_q[WORD_W-1:0];

  // prev_q carries the last reconstructed word so the predictor chains across steps.
  always_comb begin
    work_data_d = work_data_q;
    work_pred_d = work_pred_q;
    prev_d      = prev_q;
    word        = '0;
    p           = '0;
    o           = '0;
    k           = 0;
    for (int l = 0; l < LANES; l++) begin
      k    = int'(step_q) * LANES + l;
      word = in_q[k*WORD_W +: WORD_W];
      if (k == 0) begin
        p = '0;
        o = word;
      end else begin
        unique case (mode_q)
          2'd0: begin p = '0;     o = word;          end
          2'd1: begin p = prev_d; o = word + prev_d; end
          2'd2: begin p = prev_d; o = word ^ prev_d; end
          default: begin p = base; o = base + word;  end
        endcase
      end
      work_data_d[k*WORD_W +: WORD_W] = o;
      work_pred_d[k*WORD_W +: WORD_W] = p;
      prev_d = o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_q        <= '0;
      mode_q      <= '0;
      step_q      <= '0;
      prev_q      <= '0;
      work_data_q <= '0;
      work_pred_q <= '0;
      data_o      <= '0;
      pred_o      <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            in_q    <= data_i;
            mode_q  <= mode_i;
            step_q  <= '0;
            prev_q  <= '0;
            state_q <= StCalc;
            busy_o  <= 1'b1;
          end
        end
        StCalc: begin
          work_data_q <= work_data_d;
          work_pred_q <= work_pred_d;
          prev_q      <= prev_d;
          if (last_step) begin
            data_o  <= work_data_d;
            pred_o  <= work_pred_d;
            step_q  <= '0;
            state_q <= StHold;
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        StHold: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            if (accept) begin
              // Output handshake and new input accepted on the same edge.
              in_q    <= data_i;
              mode_q  <= mode_i;
              step_q  <= '0;
              prev_q  <= '0;
              state_q <= StCalc;
              busy_o  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_detransformer_pipe.sv
// Scoreboard bench for detransformer_pipe: directed lines with hand-computed results, plus
// latency, backpressure, back-to-back and mid-line reset checks.
module tb_detransformer_pipe;

  logic         clk, rst, valid_i, ready_o, valid_o, ready_i, busy_o;
  logic [1:0]   mode_i;
  logic [255:0] data_i, data_o, pred_o;

  typedef struct packed {
    logic [255:0] d;
    logic [255:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;

  detransformer_pipe #(.DATA_W(256), .WORD_W(32), .LANES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mode_i  (mode_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .pred_o  (pred_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one line until accepted; optionally queues its expected result.
  task automatic send(input logic [1:0] m, input logic [255:0] d, input logic [255:0] ed,
                      input logic [255:0] ep, input bit push);
    int   n;
    exp_t e;
    n = 0;
    mode_i  = m;
    data_i  = d;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      chk("accept_timeout", ready_o, 1);
      valid_i = 1'b0;
      return;
    end
    if (push) begin
      e.d = ed;
      e.p = ep;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: pops on every output handshake and checks first-cycle latency.
  always @(negedge clk) begin
    if (!rst && valid_o && !prev_v) chk("latency", cyc - acc_cyc, 4);
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", valid_o, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data_o", data_o, mon_e.d);
        chk("pred_o", pred_o, mon_e.p);
      end
    end
    prev_v = valid_o;
  end

  logic [255:0] ones, e1d, e1p, v2, e2d, e2p, v3, e3d, e3p, v5, e5d, e5p;
  int seen;

  initial begin
    ones = pk(1, 1, 1, 1, 1, 1, 1, 1);
    e1d  = pk(1, 2, 3, 4, 5, 6, 7, 8);
    e1p  = pk(0, 1, 2, 3, 4, 5, 6, 7);
    v2   = pk(32'hFFFFFFFF, 2, 0, 0, 0, 0, 0, 0);
    e2d  = pk(32'hFFFFFFFF, 1, 1, 1, 1, 1, 1, 1);
    e2p  = pk(0, 32'hFFFFFFFF, 1, 1, 1, 1, 1, 1);
    v3   = pk(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
              32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    e3d  = pk(32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);
    e3p  = pk(0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
    v5   = pk(32'h100, 1, 1, 1, 1, 1, 1, 1);
    e5d  = pk(32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h101, 32'h101, 32'h101);
    e5p  = pk(0, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100);

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; mode_i = '0; data_i = '0;
    @(negedge clk);
    chk("ready_in_reset", ready_o, 0);
    @(posedge clk); #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_pred", pred_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready_o, 1);
    @(posedge clk); #1;

    // Mode sweep, issued back-to-back with ready_i held high.
    send(2'd1, ones, e1d, e1p, 1);
    @(negedge clk);
    chk("busy_in_calc", busy_o, 1);
    @(posedge clk); #1;
    send(2'd1, v2, e2d, e2p, 1);
    send(2'd2, v3, e3d, e3p, 1);
    send(2'd0, v3, v3, '0, 1);
    send(2'd3, v5, e5d, e5p, 1);
    drain(40);

    // Backpressure, then release together with a new line.
    ready_i = 1'b0;
    send(2'd1, ones, e1d, e1p, 1);
    seen = 0;
    while (!valid_o && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_valid_seen", valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", valid_o, 1);
      chk("bp_data", data_o, e1d);
      chk("bp_pred", pred_o, e1p);
      chk("bp_ready", ready_o, 0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(2'd3, v5, e5d, e5p, 1);
    @(negedge clk);
    chk("b2b_busy", busy_o, 1);
    drain(40);

    // Reset during step 2 of a line that must never appear.
    @(posedge clk); #1;
    send(2'd1, ones, '0, '0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_reset", ready_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_data", data_o, 0);
    chk("abort_pred", pred_o, 0);
    @(negedge clk);
    chk("abort_ready", ready_o, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("abort_no_valid", seen, 0);
    @(posedge clk); #1;
    send(2'd3, v5, e5d, e5p, 1);
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
